id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage_if.sv | 60 ++++++
 rtl/id_ex_stage.sv | 131 +++++++++++++
 tb/tb_id_ex_stage.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if -- signal bundle between the ID stage, the ID/EX pipeline
// register and the EX stage.
//
// Optional feature macro: IDEX_HAZARD_CNT_EN adds the 16-bit stall_cnt signal.
//
// Signals:
//   flush                  ID->reg  squash the ID-stage instruction (taken branch/jump)
//   ctrl_id[14:0]          ID->reg  decoder bundle {jump,RegDst,Branch,MemR,Mem2R,
//                                   MemW,RegW,Alusrc,EXtOp[1:0],ALUOp[4:0]}
//   rs_id, rt_id, rd_id    ID->reg  register fields
//   rd1_id, rd2_id         ID->reg  register-file read data
//   imm16_id               ID->reg  raw immediate
//   pc4_id                 ID->reg  PC+4
//   ctrl_ex .. pc4_ex      reg->EX  registered copies (wreg_ex = chosen destination)
//   valid_ex               reg->EX  1 = real instruction, 0 = bubble
//   stall                  reg->ID  combinational hold request for PC and IF/ID
//   stall_cnt              reg->ID  saturating stall counter (macro only)
//
// Modports: master = ID/test side that drives the ID fields; slave = the stage.
interface id_ex_stage_if;
    logic        flush;
    logic [14:0] ctrl_id;
    logic [4:0]  rs_id;
    logic [4:0]  rt_id;
    logic [4:0]  rd_id;
    logic [31:0] rd1_id;
    logic [31:0] rd2_id;
    logic [15:0] imm16_id;
    logic [31:0] pc4_id;

    logic [14:0] ctrl_ex;
    logic [4:0]  rs_ex;
    logic [4:0]  rt_ex;
    logic [4:0]  wreg_ex;
    logic [31:0] a_ex;
    logic [31:0] b_ex;
    logic [31:0] imm_ex;
    logic [31:0] pc4_ex;
    logic        valid_ex;
    logic        stall;
`ifdef IDEX_HAZARD_CNT_EN
    logic [15:0] stall_cnt;
`endif

    modport master (
        output flush, ctrl_id, rs_id, rt_id, rd_id, rd1_id, rd2_id, imm16_id, pc4_id,
        input  ctrl_ex, rs_ex, rt_ex, wreg_ex, a_ex, b_ex, imm_ex, pc4_ex, valid_ex, stall
`ifdef IDEX_HAZARD_CNT_EN
        , input stall_cnt
`endif
    );

    modport slave (
        input  flush, ctrl_id, rs_id, rt_id, rd_id, rd1_id, rd2_id, imm16_id, pc4_id,
        output ctrl_ex, rs_ex, rt_ex, wreg_ex, a_ex, b_ex, imm_ex, pc4_ex, valid_ex, stall
`ifdef IDEX_HAZARD_CNT_EN
        , output stall_cnt
`endif
    );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage -- ID/EX pipeline register with immediate extension, destination
// selection and load-use hazard detection.
//
// Optional feature macro: IDEX_HAZARD_CNT_EN adds a 16-bit saturating counter of
// stall cycles on bus.stall_cnt; without it the counter does not exist.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset; dominates flush and hazard
//   bus   id_ex_stage_if.slave (ID-side inputs, EX-side registered outputs,
//         combinational stall)
//
// Handshake: stall is a combinational request to hold PC and IF/ID for one
// cycle. While it is high this stage loads a bubble, so the next cycle the
// same ID instruction is re-presented and finds no hazard.
module id_ex_stage (
    input  logic           clk,
    input  logic           rst,
    id_ex_stage_if.slave   bus
);
    // Bit positions inside the 15-bit control bundle.
    localparam int B_REGDST = 13;
    localparam int B_BRANCH = 12;
    localparam int B_MEMR   = 11;
    localparam int B_MEMW   = 9;
    localparam int B_REGW   = 8;

    // EXtOp encodings.
    localparam logic [1:0] EXT_ZERO    = 2'b00;
    localparam logic [1:0] EXT_SIGNED  = 2'b01;
    localparam logic [1:0] EXT_HIGHPOS = 2'b10;

    logic [14:0] ctrl_q;
    logic [4:0]  rs_q;
    logic [4:0]  rt_q;
    logic [4:0]  wreg_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [31:0] imm_q;
    logic [31:0] pc4_q;
    logic        valid_q;

    logic [31:0] imm_ext;
    logic [4:0]  wreg_d;
    logic        hazard;
    logic        bubble;

    always_comb begin
        imm_ext = {16'h0000, bus.imm16_id};
        case (bus.ctrl_id[6:5])
            EXT_ZERO:    imm_ext = {16'h0000, bus.imm16_id};
            EXT_SIGNED:  imm_ext = {{16{bus.imm16_id[15]}}, bus.imm16_id};
            EXT_HIGHPOS: imm_ext = {bus.imm16_id, 16'h0000};
            default:     imm_ext = {16'h0000, bus.imm16_id};
        endcase
    end

    // Non-writing instructions carry destination 0 so they can never look like
    // a hazard source further down the pipe.
    always_comb begin
        wreg_d = 5'd0;
        if (bus.ctrl_id[B_REGW])
            wreg_d = bus.ctrl_id[B_REGDST] ? bus.rd_id : bus.rt_id;
    end

    // rt is only a true source for R-type, stores and branches; for I-type ALU
    // ops and loads it is the destination, so matching it is not a hazard.
    always_comb begin
        hazard = valid_q && ctrl_q[B_MEMR] && (wreg_q != 5'd0) &&
                 ((wreg_q == bus.rs_id) ||
                  ((wreg_q == bus.rt_id) &&
                   (bus.ctrl_id[B_REGDST] || bus.ctrl_id[B_MEMW] || bus.ctrl_id[B_BRANCH])));
    end

    assign bubble    = hazard || bus.flush;
    assign bus.stall = hazard && !bus.flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q  <= 15'd0;
            rs_q    <= 5'd0;
            rt_q    <= 5'd0;
            wreg_q  <= 5'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            imm_q   <= 32'd0;
            pc4_q   <= 32'd0;
            valid_q <= 1'b0;
        end else begin
            // Data fields load every cycle; on a bubble they are don't-care.
            rs_q  <= bus.rs_id;
            rt_q  <= bus.rt_id;
            a_q   <= bus.rd1_id;
            b_q   <= bus.rd2_id;
            imm_q <= imm_ext;
            pc4_q <= bus.pc4_id;
            if (bubble) begin
                ctrl_q  <= 15'd0;
                wreg_q  <= 5'd0;
                valid_q <= 1'b0;
            end else begin
                ctrl_q  <= bus.ctrl_id;
                wreg_q  <= wreg_d;
                valid_q <= 1'b1;
            end
        end
    end

    assign bus.ctrl_ex  = ctrl_q;
    assign bus.rs_ex    = rs_q;
    assign bus.rt_ex    = rt_q;
    assign bus.wreg_ex  = wreg_q;
    assign bus.a_ex     = a_q;
    assign bus.b_ex     = b_q;
    assign bus.imm_ex   = imm_q;
    assign bus.pc4_ex   = pc4_q;
    assign bus.valid_ex = valid_q;

`ifdef IDEX_HAZARD_CNT_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt_q <= 16'd0;
        else if (bus.stall && (stall_cnt_q != 16'hFFFF))
            stall_cnt_q <= stall_cnt_q + 16'd1;
    end

    assign bus.stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage -- directed-vector bench for id_ex_stage with hand-computed
// expectations. Define IDEX_HAZARD_CNT_EN to also cover the stall counter.
module tb_id_ex_stage;
    // Control bundles {jump,RegDst,Branch,MemR,Mem2R,MemW,RegW,Alusrc,EXtOp,ALUOp}
    localparam logic [14:0] C_ADDU = 15'h2101; // RegDst,RegW, ALUOp=1
    localparam logic [14:0] C_LW   = 15'h0DA1; // MemR,Mem2R,RegW,Alusrc,EXT_SIGNED
    localparam logic [14:0] C_ORI  = 15'h0183; // RegW,Alusrc,EXT_ZERO
    localparam logic [14:0] C_LUI  = 15'h01C4; // RegW,Alusrc,EXT_HIGHPOS
    localparam logic [14:0] C_EXT3 = 15'h01E0; // RegW,Alusrc,EXtOp=11
    localparam logic [14:0] C_SW   = 15'h02A1; // MemW,Alusrc,EXT_SIGNED
    localparam logic [14:0] C_BEQ  = 15'h1022; // Branch,EXT_SIGNED
    localparam logic [14:0] C_J    = 15'h4000; // jump

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    id_ex_stage_if bus ();

    id_ex_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // clock/reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Data fields are derived from the register numbers so expectations follow.
    task automatic drive_id(input logic [14:0] c, input logic [4:0] rs, input logic [4:0] rt,
                            input logic [4:0] rd, input logic [15:0] imm);
        bus.ctrl_id  = c;
        bus.rs_id    = rs;
        bus.rt_id    = rt;
        bus.rd_id    = rd;
        bus.rd1_id   = 32'hA000_0000 | {27'd0, rs};
        bus.rd2_id   = 32'hB000_0000 | {27'd0, rt};
        bus.imm16_id = imm;
        bus.pc4_id   = 32'h0040_0000 | {27'd0, rd};
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle_stall(input string tag, input logic exp);
        #1;
        check(tag, {31'd0, bus.stall}, {31'd0, exp});
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.flush = 1'b0;
        drive_id(15'h7FFF, 5'd31, 5'd31, 5'd31, 16'hFFFF);
        step();
        check("rst_ctrl", {17'd0, bus.ctrl_ex}, 32'd0);
        check("rst_valid", {31'd0, bus.valid_ex}, 32'd0);
        check("rst_wreg", {27'd0, bus.wreg_ex}, 32'd0);
        check("rst_rs_rt", {22'd0, bus.rs_ex, bus.rt_ex}, 32'd0);
        check("rst_a", bus.a_ex, 32'd0);
        check("rst_b", bus.b_ex, 32'd0);
        check("rst_imm", bus.imm_ex, 32'd0);
        check("rst_pc4", bus.pc4_ex, 32'd0);
        check("rst_stall", {31'd0, bus.stall}, 32'd0);
`ifdef IDEX_HAZARD_CNT_EN
        check("rst_cnt", {16'd0, bus.stall_cnt}, 32'd0);
`endif
        rst = 1'b0;

        // addu rs=1 rt=2 rd=3
        drive_id(C_ADDU, 5'd1, 5'd2, 5'd3, 16'h1234);
        settle_stall("addu_stall", 1'b0);
        step();
        check("addu_ctrl", {17'd0, bus.ctrl_ex}, {17'd0, C_ADDU});
        check("addu_valid", {31'd0, bus.valid_ex}, 32'd1);
        check("addu_wreg", {27'd0, bus.wreg_ex}, 32'd3);
        check("addu_rs_rt", {22'd0, bus.rs_ex, bus.rt_ex}, {22'd0, 5'd1, 5'd2});
        check("addu_a", bus.a_ex, 32'hA000_0001);
        check("addu_b", bus.b_ex, 32'hB000_0002);
        check("addu_imm", bus.imm_ex, 32'h0000_1234);
        check("addu_pc4", bus.pc4_ex, 32'h0040_0003);

        // lw rt=5 then addu rs=5: one bubble, then addu enters EX
        drive_id(C_LW, 5'd1, 5'd5, 5'd7, 16'h0004);
        step();
        check("lw_wreg", {27'd0, bus.wreg_ex}, 32'd5);
        check("lw_imm", bus.imm_ex, 32'h0000_0004);
        drive_id(C_ADDU, 5'd5, 5'd2, 5'd3, 16'h0000);
        settle_stall("lu_stall", 1'b1);
        step();
        check("lu_bub_ctrl", {17'd0, bus.ctrl_ex}, 32'd0);
        check("lu_bub_valid", {31'd0, bus.valid_ex}, 32'd0);
        check("lu_bub_wreg", {27'd0, bus.wreg_ex}, 32'd0);
        check("lu_stall_drop", {31'd0, bus.stall}, 32'd0);
        step();
        check("lu_addu_ctrl", {17'd0, bus.ctrl_ex}, {17'd0, C_ADDU});
        check("lu_addu_valid", {31'd0, bus.valid_ex}, 32'd1);
        check("lu_addu_wreg", {27'd0, bus.wreg_ex}, 32'd3);
        check("lu_addu_rs", {27'd0, bus.rs_ex}, 32'd5);

        // lw rt=5 then ori rs=4 rt=5: rt is a destination, no hazard
        drive_id(C_LW, 5'd1, 5'd5, 5'd7, 16'h0000);
        step();
        drive_id(C_ORI, 5'd4, 5'd5, 5'd9, 16'h8001);
        settle_stall("ori_stall", 1'b0);
        step();
        check("ori_ctrl", {17'd0, bus.ctrl_ex}, {17'd0, C_ORI});
        check("ori_valid", {31'd0, bus.valid_ex}, 32'd1);
        check("ori_wreg", {27'd0, bus.wreg_ex}, 32'd5);
        check("ori_imm_zero", bus.imm_ex, 32'h0000_8001);

        // lw into $0 never stalls
        drive_id(C_LW, 5'd1, 5'd0, 5'd7, 16'h0000);
        step();
        check("lw0_wreg", {27'd0, bus.wreg_ex}, 32'd0);
        drive_id(C_ADDU, 5'd0, 5'd2, 5'd3, 16'h0000);
        settle_stall("lw0_stall", 1'b0);
        step();
        check("lw0_addu_valid", {31'd0, bus.valid_ex}, 32'd1);

        // immediate extension modes
        drive_id(C_LW, 5'd2, 5'd6, 5'd0, 16'h8001);
        step();
        check("imm_signed", bus.imm_ex, 32'hFFFF_8001);
        drive_id(C_LUI, 5'd0, 5'd8, 5'd0, 16'h8001);
        settle_stall("lui_stall", 1'b0);
        step();
        check("imm_highpos", bus.imm_ex, 32'h8001_0000);
        check("lui_wreg", {27'd0, bus.wreg_ex}, 32'd8);
        drive_id(C_EXT3, 5'd0, 5'd9, 5'd0, 16'h8001);
        step();
        check("imm_other", bus.imm_ex, 32'h0000_8001);

        // lw then sw rt=5: store data dependency stalls; sw has no destination
        drive_id(C_LW, 5'd1, 5'd5, 5'd7, 16'h0000);
        step();
        drive_id(C_SW, 5'd3, 5'd5, 5'd0, 16'hFFFC);
        settle_stall("sw_stall", 1'b1);
        step();
        check("sw_bub_valid", {31'd0, bus.valid_ex}, 32'd0);
        step();
        check("sw_ctrl", {17'd0, bus.ctrl_ex}, {17'd0, C_SW});
        check("sw_wreg", {27'd0, bus.wreg_ex}, 32'd0);
        check("sw_imm", bus.imm_ex, 32'hFFFF_FFFC);

        // lw then beq rt=5
        drive_id(C_LW, 5'd1, 5'd5, 5'd7, 16'h0000);
        step();
        drive_id(C_BEQ, 5'd4, 5'd5, 5'd0, 16'h0000);
        settle_stall("beq_stall", 1'b1);
        step();
        check("beq_bub_ctrl", {17'd0, bus.ctrl_ex}, 32'd0);
        step();
        check("beq_ctrl", {17'd0, bus.ctrl_ex}, {17'd0, C_BEQ});
        check("beq_valid", {31'd0, bus.valid_ex}, 32'd1);

        // load-use with flush in the same cycle: no stall, bubble loaded
        drive_id(C_LW, 5'd1, 5'd5, 5'd7, 16'h0000);
        step();
        drive_id(C_ADDU, 5'd5, 5'd2, 5'd3, 16'h0000);
        bus.flush = 1'b1;
        settle_stall("flush_stall", 1'b0);
        step();
        bus.flush = 1'b0;
        check("flush_ctrl", {17'd0, bus.ctrl_ex}, 32'd0);
        check("flush_valid", {31'd0, bus.valid_ex}, 32'd0);
        check("flush_wreg", {27'd0, bus.wreg_ex}, 32'd0);

        // jump bundle passes unchanged
        drive_id(C_J, 5'd0, 5'd0, 5'd0, 16'h0010);
        step();
        check("jump_ctrl", {17'd0, bus.ctrl_ex}, {17'd0, C_J});
        check("jump_valid", {31'd0, bus.valid_ex}, 32'd1);

`ifdef IDEX_HAZARD_CNT_EN
        check("stall_cnt", {16'd0, bus.stall_cnt}, 32'd3);
`endif

        // reset dominates flush
        drive_id(C_ADDU, 5'd1, 5'd2, 5'd3, 16'h0000);
        rst = 1'b1;
        bus.flush = 1'b1;
        step();
        rst = 1'b0;
        bus.flush = 1'b0;
        check("rst2_valid", {31'd0, bus.valid_ex}, 32'd0);
        check("rst2_a", bus.a_ex, 32'd0);
`ifdef IDEX_HAZARD_CNT_EN
        check("rst2_cnt", {16'd0, bus.stall_cnt}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
